mem_delayed: RTL and testbench

- Word-addressed, 32-bit-wide main memory.
- Sits directly downstream of the processor's memory port and serves both instruction fetches and data loads/stores.
- Models configurable fixed access latency, using the processor's existing req/ack/busy handshake.
- Provides a testbench backdoor for preloading programs while idle.

---
 rtl/mem_pkg.sv | 22 ++
 rtl/mem_array.sv | 45 ++++
 rtl/mem_delayed.sv | 172 +++++++++++++++++
 tb/tb_mem_delayed.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// ----------------------------------------------------------------------------
// mem_pkg
// Shared types and constants for the fixed-latency main memory model.
//   e_mem_state : controller state (IDLE / BUSY)
//   e_mem_op    : latched operation kind (MEM_RD / MEM_WR)
//   DATA_W      : memory word width in bits
// ----------------------------------------------------------------------------
package mem_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } e_mem_state;

  typedef enum logic {
    MEM_RD = 1'b0,
    MEM_WR = 1'b1
  } e_mem_op;

endpackage : mem_pkg

// File: rtl/mem_array.sv
// ----------------------------------------------------------------------------
// mem_array
// Single-port-write, single-port-read word array with registered read data.
// Contents are never reset; preloading is done through the write port.
// Ports:
//   clk_i   : clock, all updates on posedge
//   we_i    : write enable
//   waddr_i : write word index
//   wdata_i : write data
//   re_i    : read enable; rdata_o captures array[raddr_i] when set
//   raddr_i : read word index
//   rdata_o : registered read data, held while re_i is low
// ----------------------------------------------------------------------------
module mem_array
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter string       MEM_INIT   = ""
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_W-1:0]     rdata_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : mem_array

// File: rtl/mem_delayed.sv
// ----------------------------------------------------------------------------
// mem_delayed
// Word-addressed 32-bit main memory with a fixed access latency, serving the
// processor memory port through a req/ack/busy handshake, plus a backdoor
// load port usable only while idle.
// Ports:
//   clk          : clock, all state changes on posedge
//   rst          : asynchronous reset, active-low
//   mem_addr     : word address, sampled when a request is accepted
//   mem_wr_data  : write data, sampled when a request is accepted
//   mem_rd_req   : read request pulse
//   mem_wr_req   : write request pulse (wins over a simultaneous read)
//   mem_rd_data  : read result, valid with mem_ack and held until next read
//   mem_ack      : one-cycle completion pulse
//   mem_busy     : registered, high while a request is in flight
//   mem_err      : one-cycle pulse with mem_ack for out-of-range addresses
//   ld_en/ld_addr/ld_data : backdoor write, honoured only in IDLE with no
//                  request in the same cycle
// MEM_LATENCY must lie in 1..15 (4-bit countdown).
// ----------------------------------------------------------------------------
module mem_delayed
  import mem_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 5,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter string       MEM_INIT    = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           mem_addr,
  input  logic [DATA_W-1:0]     mem_wr_data,
  input  logic                  mem_rd_req,
  input  logic                  mem_wr_req,
  output logic [DATA_W-1:0]     mem_rd_data,
  output logic                  mem_ack,
  output logic                  mem_busy,
  output logic                  mem_err,
  input  logic                  ld_en,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_W-1:0]     ld_data
);

  localparam logic [3:0] LAT_INIT = 4'(MEM_LATENCY - 1);

  // Control state (asynchronously reset)
  e_mem_state        state_q,   state_d;
  logic [3:0]        cnt_q,     cnt_d;
  logic              ack_q,     ack_d;
  logic              err_q,     err_d;
  logic              busy_q,    busy_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  // Latched request (no reset needed: only consumed while BUSY)
  e_mem_op                op_q,    op_d;
  logic [ADDR_WIDTH-1:0]  addr_q,  addr_d;
  logic                   oor_q,   oor_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;

  logic                  req;
  logic                  req_oor;
  logic                  accept;
  logic                  core_we;
  logic                  ld_we;
  logic                  arr_we;
  logic [ADDR_WIDTH-1:0] arr_waddr;
  logic [DATA_W-1:0]     arr_wdata;
  logic [DATA_W-1:0]     arr_rdata;

  assign req     = mem_rd_req | mem_wr_req;
  assign req_oor = |mem_addr[31:ADDR_WIDTH];
  assign accept  = (state_q == IDLE) && req;

  // Core write happens on the completion edge; the backdoor only when the
  // controller is idle and nobody is requesting, so the two never collide.
  assign core_we   = (state_q == BUSY) && (cnt_q == 4'd0) &&
                     (op_q == MEM_WR) && !oor_q;
  assign ld_we     = (state_q == IDLE) && !req && ld_en;
  assign arr_we    = core_we | ld_we;
  assign arr_waddr = core_we ? addr_q  : ld_addr;
  assign arr_wdata = core_we ? wdata_q : ld_data;

  // The array read is launched at acceptance so the data is already
  // registered by the completion edge, even with MEM_LATENCY = 1. Nothing
  // can write the array while BUSY before completion, so it cannot go stale.
  mem_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .MEM_INIT   (MEM_INIT)
  ) u_array (
    .clk_i   (clk),
    .we_i    (arr_we),
    .waddr_i (arr_waddr),
    .wdata_i (arr_wdata),
    .re_i    (accept),
    .raddr_i (mem_addr[ADDR_WIDTH-1:0]),
    .rdata_o (arr_rdata)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    busy_d    = busy_q;
    rd_data_d = rd_data_q;
    op_d      = op_q;
    addr_d    = addr_q;
    oor_d     = oor_q;
    wdata_d   = wdata_q;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d = BUSY;
          cnt_d   = LAT_INIT;
          op_d    = mem_wr_req ? MEM_WR : MEM_RD;
          addr_d  = mem_addr[ADDR_WIDTH-1:0];
          oor_d   = req_oor;
          wdata_d = mem_wr_data;
          busy_d  = 1'b1;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          ack_d   = 1'b1;
          err_d   = oor_q;
          if (op_q == MEM_RD) begin
            rd_data_d = oor_q ? '0 : arr_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q    <= op_d;
    addr_q  <= addr_d;
    oor_q   <= oor_d;
    wdata_q <= wdata_d;
  end

  assign mem_rd_data = rd_data_q;
  assign mem_ack     = ack_q;
  assign mem_busy    = busy_q;
  assign mem_err     = err_q;

endmodule : mem_delayed

// File: tb/tb_mem_delayed.sv
// ----------------------------------------------------------------------------
// tb_mem_delayed
// Directed-vector bench for mem_delayed (MEM_LATENCY=5, ADDR_WIDTH=10).
// Inputs change 1 time unit after posedge; outputs are sampled there too.
// ----------------------------------------------------------------------------
module tb_mem_delayed;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wr_data;
  logic          mem_rd_req;
  logic          mem_wr_req;
  logic [31:0]   mem_rd_data;
  logic          mem_ack;
  logic          mem_busy;
  logic          mem_err;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_delayed #(
    .MEM_LATENCY (5),
    .ADDR_WIDTH  (AW),
    .MEM_INIT    ("")
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_rd_req  (mem_rd_req),
    .mem_wr_req  (mem_wr_req),
    .mem_rd_data (mem_rd_data),
    .mem_ack     (mem_ack),
    .mem_busy    (mem_busy),
    .mem_err     (mem_err),
    .ld_en       (ld_en),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic backdoor(input int a, input logic [31:0] d);
    ld_en   = 1'b1;
    ld_addr = AW'(a);
    ld_data = d;
    tick();
    ld_en   = 1'b0;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    mem_rd_req  = rd;
    mem_wr_req  = wr;
    mem_addr    = a;
    mem_wr_data = d;
    tick();
    mem_rd_req  = 1'b0;
    mem_wr_req  = 1'b0;
  endtask

  // Cycles from the last edge until mem_ack is seen; 20 means it never came.
  task automatic wait_ack(output int lat);
    lat = 0;
    while (!mem_ack && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic count_acks(input int n, output int acks);
    acks = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (mem_ack) acks++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int acks;

    rst         = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    mem_rd_req  = 1'b0;
    mem_wr_req  = 1'b0;
    ld_en       = 1'b0;
    ld_addr     = '0;
    ld_data     = '0;
    repeat (3) tick();

    chk("rst_ack",  32'(mem_ack),  32'd0);
    chk("rst_busy", 32'(mem_busy), 32'd0);
    chk("rst_err",  32'(mem_err),  32'd0);
    chk("rst_rdat", mem_rd_data,   32'd0);

    rst = 1'b1;
    tick();

    backdoor(3, 32'h0000_0342);
    backdoor(0, 32'hA5A5_0000);
    backdoor(1, 32'h0000_0111);
    backdoor(2, 32'h0000_0222);
    backdoor(4, 32'h0000_0444);
    backdoor(5, 32'h0000_0505);
    backdoor(7, 32'h0000_0000);
    backdoor(9, 32'h0000_0000);

    // Backdoor-loaded read, cycle-exact latency
    issue(1'b1, 1'b0, 32'd3, 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("t1_busy",  32'(mem_busy), 32'd1);
      chk("t1_noack", 32'(mem_ack),  32'd0);
      tick();
    end
    chk("t1_ack",  32'(mem_ack),  32'd1);
    chk("t1_busy_lo", 32'(mem_busy), 32'd0);
    chk("t1_err",  32'(mem_err),  32'd0);
    chk("t1_rdat", mem_rd_data,   32'h0000_0342);
    repeat (10) tick();
    chk("t1_hold", mem_rd_data,   32'h0000_0342);
    chk("t1_ack_lo", 32'(mem_ack), 32'd0);

    // Write then back-to-back read issued in the ack cycle
    issue(1'b0, 1'b1, 32'd7, 32'hDEAD_BEEF);
    wait_ack(lat);
    chk("t2_wlat",  32'(lat),    32'd5);
    chk("t2_wkeep", mem_rd_data, 32'h0000_0342);
    issue(1'b1, 1'b0, 32'd7, 32'd0);
    wait_ack(lat);
    chk("t2_rlat",  32'(lat),    32'd5);
    chk("t2_rdat",  mem_rd_data, 32'hDEAD_BEEF);
    count_acks(8, acks);
    chk("t2_extra", 32'(acks),   32'd0);

    // Request while busy is dropped
    issue(1'b1, 1'b0, 32'd1, 32'd0);
    tick();
    issue(1'b1, 1'b0, 32'd2, 32'd0);
    wait_ack(lat);
    chk("t3_lat",   32'(lat),    32'd3);
    chk("t3_rdat",  mem_rd_data, 32'h0000_0111);
    count_acks(10, acks);
    chk("t3_extra", 32'(acks),   32'd0);

    // Simultaneous rd+wr acts as a write
    issue(1'b1, 1'b1, 32'd4, 32'h0000_0055);
    wait_ack(lat);
    chk("t4_lat",   32'(lat),    32'd5);
    chk("t4_keep",  mem_rd_data, 32'h0000_0111);
    issue(1'b1, 1'b0, 32'd4, 32'd0);
    wait_ack(lat);
    chk("t4_rdat",  mem_rd_data, 32'h0000_0055);

    // Out-of-range address
    issue(1'b1, 1'b0, 32'h0000_0400, 32'd0);
    wait_ack(lat);
    chk("t5_lat",   32'(lat),    32'd5);
    chk("t5_err",   32'(mem_err), 32'd1);
    chk("t5_rdat",  mem_rd_data, 32'd0);
    tick();
    chk("t5_err_lo", 32'(mem_err), 32'd0);
    chk("t5_ack_lo", 32'(mem_ack), 32'd0);
    issue(1'b0, 1'b1, 32'h0000_0400, 32'hFFFF_FFFF);
    wait_ack(lat);
    chk("t5_werr",  32'(mem_err), 32'd1);
    issue(1'b1, 1'b0, 32'd0, 32'd0);
    wait_ack(lat);
    chk("t5_a0",    mem_rd_data, 32'hA5A5_0000);
    chk("t5_a0err", 32'(mem_err), 32'd0);

    // Backdoor ignored while busy
    issue(1'b1, 1'b0, 32'd5, 32'd0);
    ld_en   = 1'b1;
    ld_addr = AW'(5);
    ld_data = 32'h0000_0999;
    tick();
    tick();
    ld_en   = 1'b0;
    wait_ack(lat);
    chk("t6_rdat",  mem_rd_data, 32'h0000_0505);
    issue(1'b1, 1'b0, 32'd5, 32'd0);
    wait_ack(lat);
    chk("t6_kept",  mem_rd_data, 32'h0000_0505);

    // Reset aborts an in-flight write
    issue(1'b0, 1'b1, 32'd9, 32'h0000_0001);
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("t7_busy",  32'(mem_busy), 32'd0);
    chk("t7_ack",   32'(mem_ack),  32'd0);
    chk("t7_rdat",  mem_rd_data,   32'd0);
    count_acks(6, acks);
    chk("t7_noack", 32'(acks),     32'd0);
    rst = 1'b1;
    tick();
    issue(1'b1, 1'b0, 32'd9, 32'd0);
    wait_ack(lat);
    chk("t7_lat",   32'(lat),      32'd5);
    chk("t7_a9",    mem_rd_data,   32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule : tb_mem_delayed
